// File: rtl/pipelined_dadda_multiplier.sv
// ---------------------------------------------------------------------------
// pipelined_dadda_multiplier
//
// Three-stage WIDTH x WIDTH multiplier with a valid/ready stream interface.
//   S1: partial-product AND array, registered
//   S2: Dadda column reduction (heights 2,3,4,6,9,13,...) to two rows, registered
//   S3: carry-propagate add of the two rows, registered into product
//
// Build option: define DADDA_SIGNED_EN to add Baugh-Wooley signed
// multiplication, selected per operand pair by signed_mode. Without it,
// every operation is unsigned and signed_mode is ignored.
//
// Parameters
//   WIDTH        operand width, 4..16
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   A, B         operands (WIDTH bits)
//   signed_mode  1: operands are two's complement (only with DADDA_SIGNED_EN)
//   in_valid     operand pair valid
//   in_ready     block accepts an operand pair this cycle
//   product      full 2*WIDTH-bit result
//   out_valid    product valid
//   out_ready    consumer takes product this cycle
// ---------------------------------------------------------------------------
module pipelined_dadda_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 signed_mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int W2   = 2 * WIDTH;
   // Tallest column is WIDTH bits; one spare bit keeps the shift-in pushes safe.
   localparam int MAXH = WIDTH + 1;

   // Dadda target heights: d(0)=2, d(s+1)=floor(1.5*d(s)).
   function automatic int dadda_height(input int s);
      int d;
      d = 2;
      for (int i = 0; i < s; i++) begin
         d = (d * 3) / 2;
      end
      return d;
   endfunction

   logic                w_advance;
   logic [WIDTH-1:0]    w_pp [WIDTH];
   logic [W2-1:0]       w_row0;
   logic [W2-1:0]       w_row1;

   logic                r_v1;
   logic                r_v2;
   logic [WIDTH-1:0]    r_pp [WIDTH];
   logic [W2-1:0]       r_row0;
   logic [W2-1:0]       r_row1;
   logic                w_corr;

   // The whole pipe moves as one; it only stalls when a finished result is
   // waiting on the consumer. in_ready is also held low while in reset.
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = w_advance && !reset;

   // ------------------------------------------------------------------------
   // S1 partial products. Row i holds A & B[i], weight 2^i.
   // ------------------------------------------------------------------------
`ifdef DADDA_SIGNED_EN
   logic r_corr;

   // Baugh-Wooley: invert every term that has exactly one sign bit.
   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp_row
      localparam logic [WIDTH-1:0] INV_MASK = (gi == WIDTH-1) ? ~MSB_ONLY : MSB_ONLY;
      assign w_pp[gi] = ({WIDTH{B[gi]}} & A) ^ ({WIDTH{signed_mode}} & INV_MASK);
   end

   assign w_corr = r_corr;
`else
   logic w_unused_signed_mode;
   assign w_unused_signed_mode = signed_mode;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp_row
      assign w_pp[gi] = {WIDTH{B[gi]}} & A;
   end

   assign w_corr = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // S2 Dadda reduction. Each column is a small bit bag: bits are pushed in
   // at the LSB and popped from the LSB, so the order inside a column is
   // irrelevant and unused positions stay zero.
   // ------------------------------------------------------------------------
   always_comb begin : dadda_reduce
      logic [MAXH-1:0] col [W2];
      logic [MAXH-1:0] nxt [W2];
      int              ht  [W2];
      int              nh  [W2];
      int              d;
      logic            x, y, z, sum, carry;

      x      = 1'b0;
      y      = 1'b0;
      z      = 1'b0;
      sum    = 1'b0;
      carry  = 1'b0;
      d      = 0;
      w_row0 = '0;
      w_row1 = '0;

      for (int c = 0; c < W2; c++) begin
         col[c] = '0;
         nxt[c] = '0;
         ht[c]  = 0;
         nh[c]  = 0;
      end

      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            col[i+j] = (col[i+j] << 1) | MAXH'(r_pp[i][j]);
            ht[i+j]  = ht[i+j] + 1;
         end
      end

      // Baugh-Wooley correction constants: +2^WIDTH and +2^(2*WIDTH-1).
      if (w_corr) begin
         col[WIDTH]  = (col[WIDTH] << 1) | MAXH'(1'b1);
         ht[WIDTH]   = ht[WIDTH] + 1;
         col[W2-1]   = (col[W2-1] << 1) | MAXH'(1'b1);
         ht[W2-1]    = ht[W2-1] + 1;
      end

      // Stages whose target is not below the current height are no-ops.
      for (int s = 6; s >= 0; s--) begin
         d = dadda_height(s);
         for (int c = 0; c < W2; c++) begin
            nxt[c] = '0;
            nh[c]  = 0;
         end
         for (int c = 0; c < W2; c++) begin
            // nh[c] already counts carries arriving from column c-1.
            for (int k = 0; k < MAXH; k++) begin
               if ((ht[c] + nh[c] > d) && (ht[c] >= 2)) begin
                  x = col[c][0];
                  y = col[c][1];
                  if ((ht[c] + nh[c] - d >= 2) && (ht[c] >= 3)) begin
                     z      = col[c][2];
                     col[c] = col[c] >> 3;
                     ht[c]  = ht[c] - 3;
                     sum    = x ^ y ^ z;
                     carry  = (x & y) | (x & z) | (y & z);
                  end else begin
                     col[c] = col[c] >> 2;
                     ht[c]  = ht[c] - 2;
                     sum    = x ^ y;
                     carry  = x & y;
                  end
                  nxt[c] = (nxt[c] << 1) | MAXH'(sum);
                  nh[c]  = nh[c] + 1;
                  // Carries out of the top column are beyond 2*WIDTH bits.
                  if (c < W2 - 1) begin
                     nxt[c+1] = (nxt[c+1] << 1) | MAXH'(carry);
                     nh[c+1]  = nh[c+1] + 1;
                  end
               end
            end
            for (int k = 0; k < MAXH; k++) begin
               if (ht[c] > 0) begin
                  nxt[c] = (nxt[c] << 1) | MAXH'(col[c][0]);
                  col[c] = col[c] >> 1;
                  ht[c]  = ht[c] - 1;
                  nh[c]  = nh[c] + 1;
               end
            end
         end
         for (int c = 0; c < W2; c++) begin
            col[c] = nxt[c];
            ht[c]  = nh[c];
         end
      end

      for (int c = 0; c < W2; c++) begin
         w_row0[c] = col[c][0];
         w_row1[c] = col[c][1];
      end
   end

   // ------------------------------------------------------------------------
   // Pipeline registers. Data registers load don't-care on idle cycles; only
   // the valid bits decide what is ever presented.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         out_valid <= 1'b0;
         product   <= '0;
      end else if (w_advance) begin
         r_v1      <= in_valid;
         r_v2      <= r_v1;
         out_valid <= r_v2;
         product   <= r_row0 + r_row1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_advance) begin
         r_pp   <= w_pp;
         r_row0 <= w_row0;
         r_row1 <= w_row1;
`ifdef DADDA_SIGNED_EN
         r_corr <= signed_mode;
`endif
      end
   end

endmodule

// File: tb/tb_pipelined_dadda_multiplier.sv
module tb_pipelined_dadda_multiplier;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   logic [3:0]  a4, b4;
   logic        sm4, iv4, ir4, ov4, or4;
   logic [7:0]  p4;

   logic [7:0]  a8, b8;
   logic        sm8, iv8, ir8, ov8, or8;
   logic [15:0] p8;

   int checks   = 0;
   int failures = 0;

`ifdef DADDA_SIGNED_EN
   localparam logic [15:0] EXP_S0 = 16'h0040;  // -8 * -8 = 64
   localparam logic [15:0] EXP_S1 = 16'h00F9;  // -1 *  7 = -7
   localparam logic [15:0] EXP_S2 = 16'h00C8;  // -8 *  7 = -56
`else
   localparam logic [15:0] EXP_S0 = 16'h0040;  //  8 *  8 = 64
   localparam logic [15:0] EXP_S1 = 16'h0069;  // 15 *  7 = 105
   localparam logic [15:0] EXP_S2 = 16'h0038;  //  8 *  7 = 56
`endif

   pipelined_dadda_multiplier #(.WIDTH(4)) u_dut4 (
      .clock       (clk),
      .reset       (rst),
      .A           (a4),
      .B           (b4),
      .signed_mode (sm4),
      .in_valid    (iv4),
      .in_ready    (ir4),
      .product     (p4),
      .out_valid   (ov4),
      .out_ready   (or4)
   );

   pipelined_dadda_multiplier #(.WIDTH(8)) u_dut8 (
      .clock       (clk),
      .reset       (rst),
      .A           (a8),
      .B           (b8),
      .signed_mode (sm8),
      .in_valid    (iv8),
      .in_ready    (ir8),
      .product     (p8),
      .out_valid   (ov8),
      .out_ready   (or8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      a4 = '0; b4 = '0; sm4 = 1'b0; iv4 = 1'b0; or4 = 1'b1;
      a8 = '0; b8 = '0; sm8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;

      // reset state
      tick();
      tick();
      chk("rst_in_ready4",  16'(ir4), 16'd0);
      chk("rst_out_valid4", 16'(ov4), 16'd0);
      chk("rst_product4",   16'(p4),  16'd0);
      chk("rst_in_ready8",  16'(ir8), 16'd0);
      chk("rst_out_valid8", 16'(ov8), 16'd0);
      chk("rst_product8",   p8,       16'd0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", 16'(ir4), 16'd1);

      // 5 x 12 = 60, latency of three edges from acceptance
      a4 = 4'b0101; b4 = 4'b1100; iv4 = 1'b1;
      tick();
      iv4 = 1'b0; a4 = '0; b4 = '0;
      chk("lat_edge1_valid", 16'(ov4), 16'd0);
      tick();
      chk("lat_edge2_valid", 16'(ov4), 16'd0);
      tick();
      chk("lat_edge3_valid",   16'(ov4), 16'd1);
      chk("lat_edge3_product", 16'(p4),  16'h003C);
      tick();
      chk("lat_drained", 16'(ov4), 16'd0);

      // signed_mode pairs: two's complement with the option, unsigned without
      sm4 = 1'b1; iv4 = 1'b1;
      a4 = 4'b1000; b4 = 4'b1000;
      tick();
      a4 = 4'b1111; b4 = 4'b0111;
      tick();
      a4 = 4'b1000; b4 = 4'b0111;
      tick();
      iv4 = 1'b0; sm4 = 1'b0;
      chk("sm_p0_valid", 16'(ov4), 16'd1);
      chk("sm_p0", 16'(p4), EXP_S0);
      tick();
      chk("sm_p1", 16'(p4), EXP_S1);
      tick();
      chk("sm_p2", 16'(p4), EXP_S2);
      tick();
      chk("sm_drained", 16'(ov4), 16'd0);

      // WIDTH=8 back-to-back
      a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
      tick();
      a8 = 8'h00; b8 = 8'hA5;
      tick();
      a8 = 8'h80; b8 = 8'h02;
      tick();
      chk("w8_ff_ff_valid", 16'(ov8), 16'd1);
      chk("w8_ff_ff", p8, 16'hFE01);
      a8 = 8'h37; b8 = 8'h59;
      tick();
      iv8 = 1'b0;
      chk("w8_00_a5", p8, 16'h0000);
      tick();
      chk("w8_80_02", p8, 16'h0100);
      tick();
      chk("w8_37_59", p8, 16'h131F);
      tick();
      chk("w8_drained", 16'(ov8), 16'd0);

      // backpressure: five pairs, out_ready low for cycles 4-6
      a4 = 4'd1; b4 = 4'd1; iv4 = 1'b1; or4 = 1'b1;
      #1;
      chk("bp_c1_in_ready", 16'(ir4), 16'd1);
      tick();
      a4 = 4'd2; b4 = 4'd3;
      tick();
      a4 = 4'd4; b4 = 4'd5;
      tick();
      a4 = 4'd6; b4 = 4'd7; or4 = 1'b0;
      #1;
      chk("bp_c4_in_ready", 16'(ir4), 16'd0);
      chk("bp_c4_valid",    16'(ov4), 16'd1);
      chk("bp_c4_product",  16'(p4),  16'd1);
      tick();
      chk("bp_c5_in_ready", 16'(ir4), 16'd0);
      chk("bp_c5_product",  16'(p4),  16'd1);
      tick();
      chk("bp_c6_in_ready", 16'(ir4), 16'd0);
      chk("bp_c6_valid",    16'(ov4), 16'd1);
      chk("bp_c6_product",  16'(p4),  16'd1);
      or4 = 1'b1;
      #1;
      chk("bp_c7_in_ready", 16'(ir4), 16'd1);
      tick();
      a4 = 4'd15; b4 = 4'd15;
      #1;
      chk("bp_c8_in_ready", 16'(ir4), 16'd1);
      chk("bp_c8_product",  16'(p4),  16'd6);
      tick();
      iv4 = 1'b0;
      chk("bp_c9_valid",   16'(ov4), 16'd1);
      chk("bp_c9_product", 16'(p4),  16'd20);
      tick();
      chk("bp_c10_product", 16'(p4), 16'd42);
      tick();
      chk("bp_c11_product", 16'(p4), 16'd225);
      tick();
      chk("bp_c12_valid", 16'(ov4), 16'd0);

      // reset one cycle after accepting 3 x 3
      a4 = 4'd3; b4 = 4'd3; iv4 = 1'b1;
      tick();
      iv4 = 1'b0; rst = 1'b1;
      tick();
      chk("mid_rst_valid",    16'(ov4), 16'd0);
      chk("mid_rst_in_ready", 16'(ir4), 16'd0);
      chk("mid_rst_product",  16'(p4),  16'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("mid_rst_flushed", 16'(ov4), 16'd0);
      end
      a4 = 4'd2; b4 = 4'd7; iv4 = 1'b1;
      #1;
      chk("post_rst_in_ready", 16'(ir4), 16'd1);
      tick();
      iv4 = 1'b0;
      chk("post_rst_e1_valid", 16'(ov4), 16'd0);
      tick();
      chk("post_rst_e2_valid", 16'(ov4), 16'd0);
      tick();
      chk("post_rst_e3_valid",   16'(ov4), 16'd1);
      chk("post_rst_e3_product", 16'(p4),  16'h000E);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
